aram_bus_arbiter: RTL and testbench

Arbitrates the 64 KiB audio RAM between the SPC700 CPU core and the DSP voice/echo engine. It sits directly upstream of the single-port RAM (async read, write on posedge clock) and drives that RAM's address, write-data and write-enable. Each requester uses a req/ack handshake. Read data is registered per requester. DSP has fixed priority, with a CPU starvation guard.

---
 rtl/aram_bus_arbiter_if.sv | 47 ++++
 rtl/aram_bus_arbiter.sv | 120 ++++++++++++
 tb/tb_aram_bus_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/aram_bus_arbiter_if.sv
// Bundles the CPU and DSP request ports, the RAM-side port and the grant indication of the audio RAM arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the requesters and the RAM.
interface aram_bus_arbiter_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
) ();
   logic                  cpu_req;
   logic                  cpu_we;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic                  cpu_ack;
   logic [DATA_WIDTH-1:0] cpu_rdata;

   logic                  dsp_req;
   logic                  dsp_we;
   logic [ADDR_WIDTH-1:0] dsp_addr;
   logic [DATA_WIDTH-1:0] dsp_wdata;
   logic                  dsp_ack;
   logic [DATA_WIDTH-1:0] dsp_rdata;

   logic [ADDR_WIDTH-1:0] ram_address;
   logic [DATA_WIDTH-1:0] ram_data_in;
   logic                  ram_write_enable;
   logic [DATA_WIDTH-1:0] ram_data_out;

   logic [1:0]            grant;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata,
      input  dsp_req, dsp_we, dsp_addr, dsp_wdata,
      output dsp_ack, dsp_rdata,
      output ram_address, ram_data_in, ram_write_enable,
      input  ram_data_out,
      output grant
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata,
      output dsp_req, dsp_we, dsp_addr, dsp_wdata,
      input  dsp_ack, dsp_rdata,
      input  ram_address, ram_data_in, ram_write_enable,
      output ram_data_out,
      input  grant
   );
endinterface

// File: rtl/aram_bus_arbiter.sv
// Shares the single-port audio RAM between the CPU and the DSP: one registered access cycle per grant,
// DSP has fixed priority, and a starvation counter lets the CPU win after STARVE_LIMIT consecutive losses.
module aram_bus_arbiter #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   aram_bus_arbiter_if.slave bus
);
   typedef enum logic {S_IDLE, S_ACCESS} state_e;

   localparam logic [1:0] G_NONE    = 2'b00;
   localparam logic [1:0] G_CPU     = 2'b01;
   localparam logic [1:0] G_DSP     = 2'b10;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

   state_e                state_q, state_d;
   logic [1:0]            grant_q, grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic                  cpu_ack_q, cpu_ack_d;
   logic                  dsp_ack_q, dsp_ack_d;
   logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_WIDTH-1:0] dsp_rdata_q, dsp_rdata_d;
   logic [3:0]            starve_q, starve_d;

   logic cpu_elig, dsp_elig, cpu_wins, dsp_wins;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      cpu_ack_d   = 1'b0;
      dsp_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      dsp_rdata_d = dsp_rdata_q;
      starve_d    = starve_q;

      // The requester completing this cycle still shows its old req, so it cannot win this edge.
      cpu_elig = bus.cpu_req && !(state_q == S_ACCESS && grant_q == G_CPU);
      dsp_elig = bus.dsp_req && !(state_q == S_ACCESS && grant_q == G_DSP);
      cpu_wins = cpu_elig && (!dsp_elig || starve_q >= STARVE_LIM);
      dsp_wins = dsp_elig && !cpu_wins;

      if (state_q == S_ACCESS) begin
         if (grant_q == G_CPU) begin
            cpu_ack_d = 1'b1;
            if (!we_q) cpu_rdata_d = bus.ram_data_out;
         end else if (grant_q == G_DSP) begin
            dsp_ack_d = 1'b1;
            if (!we_q) dsp_rdata_d = bus.ram_data_out;
         end
      end

      if (!bus.cpu_req || cpu_wins) begin
         starve_d = 4'd0;
      end else if (dsp_wins && cpu_elig && starve_q != 4'hF) begin
         starve_d = starve_q + 4'd1;
      end

      if (cpu_wins) begin
         state_d = S_ACCESS;
         grant_d = G_CPU;
         addr_d  = bus.cpu_addr;
         wdata_d = bus.cpu_wdata;
         we_d    = bus.cpu_we;
      end else if (dsp_wins) begin
         state_d = S_ACCESS;
         grant_d = G_DSP;
         addr_d  = bus.dsp_addr;
         wdata_d = bus.dsp_wdata;
         we_d    = bus.dsp_we;
      end else begin
         // Address and write data hold so the RAM input stays quiet while idle.
         state_d = S_IDLE;
         grant_d = G_NONE;
         we_d    = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         grant_q     <= G_NONE;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dsp_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dsp_rdata_q <= '0;
         starve_q    <= 4'd0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         cpu_ack_q   <= cpu_ack_d;
         dsp_ack_q   <= dsp_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         dsp_rdata_q <= dsp_rdata_d;
         starve_q    <= starve_d;
      end
   end

   assign bus.cpu_ack          = cpu_ack_q;
   assign bus.cpu_rdata        = cpu_rdata_q;
   assign bus.dsp_ack          = dsp_ack_q;
   assign bus.dsp_rdata        = dsp_rdata_q;
   assign bus.ram_address      = addr_q;
   assign bus.ram_data_in      = wdata_q;
   assign bus.ram_write_enable = we_q;
   assign bus.grant            = grant_q;
endmodule

// File: tb/tb_aram_bus_arbiter.sv
// Bench for the audio RAM arbiter: directed scenarios followed by randomized traffic, each cycle
// compared against a transaction-level model of owner, RAM port, acks, read data and memory contents.
module tb_aram_bus_arbiter;
   localparam int LIMIT = 4;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   aram_bus_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

   aram_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .STARVE_LIMIT(LIMIT)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   // Single-port RAM: asynchronous read, write on the rising edge.
   logic [7:0] ram_mem [0:65535];
   assign bus.ram_data_out = ram_mem[bus.ram_address];
   always @(posedge clock) if (bus.ram_write_enable) ram_mem[bus.ram_address] <= bus.ram_data_in;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: who owns the RAM for the coming cycle (0 none, 1 CPU, 2 DSP) and what it latched.
   logic [7:0]  ref_mem [0:65535];
   int          m_owner = 0;
   logic [15:0] m_addr  = '0;
   logic [7:0]  m_wdata = '0;
   logic        m_we    = 1'b0;
   logic        m_ack [2] = '{1'b0, 1'b0};
   logic [7:0]  m_rd  [2] = '{8'h00, 8'h00};
   int          m_starve = 0;

   task automatic model_edge();
      logic req [2];
      logic elig [2];
      int   done, win;
      req[0] = bus.cpu_req;
      req[1] = bus.dsp_req;
      if (reset) begin
         if (m_we) ref_mem[m_addr] = m_wdata;
         m_owner = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
         m_ack[0] = 1'b0; m_ack[1] = 1'b0; m_rd[0] = '0; m_rd[1] = '0; m_starve = 0;
         return;
      end
      done = m_owner;
      m_ack[0] = 1'b0;
      m_ack[1] = 1'b0;
      if (done != 0) begin
         if (m_we) ref_mem[m_addr] = m_wdata;
         else      m_rd[done-1] = ref_mem[m_addr];
         m_ack[done-1] = 1'b1;
      end
      elig[0] = req[0] && done != 1;
      elig[1] = req[1] && done != 2;
      if (elig[0] && elig[1]) win = (m_starve >= LIMIT) ? 1 : 2;
      else if (elig[0])       win = 1;
      else if (elig[1])       win = 2;
      else                    win = 0;
      if (!req[0] || win == 1)        m_starve = 0;
      else if (win == 2 && elig[0])   m_starve = (m_starve >= 15) ? 15 : m_starve + 1;
      m_owner = win;
      if (win == 1) begin
         m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata; m_we = bus.cpu_we;
      end else if (win == 2) begin
         m_addr = bus.dsp_addr; m_wdata = bus.dsp_wdata; m_we = bus.dsp_we;
      end else begin
         m_we = 1'b0;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clock);
      #1;
      check("grant",     32'(bus.grant),            32'(m_owner));
      check("ram_addr",  32'(bus.ram_address),      32'(m_addr));
      check("ram_wdata", 32'(bus.ram_data_in),      32'(m_wdata));
      check("ram_we",    32'(bus.ram_write_enable), 32'(m_we));
      check("cpu_ack",   32'(bus.cpu_ack),          32'(m_ack[0]));
      check("dsp_ack",   32'(bus.dsp_ack),          32'(m_ack[1]));
      check("cpu_rdata", 32'(bus.cpu_rdata),        32'(m_rd[0]));
      check("dsp_rdata", 32'(bus.dsp_rdata),        32'(m_rd[1]));
   endtask

   task automatic drive(input int id, input logic rq, input logic we, input logic [15:0] a, input logic [7:0] d);
      if (id == 0) begin
         bus.cpu_req = rq; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
      end else begin
         bus.dsp_req = rq; bus.dsp_we = we; bus.dsp_addr = a; bus.dsp_wdata = d;
      end
   endtask

   task automatic run_txn(input int id, input logic we, input logic [15:0] a, input logic [7:0] d,
                          output int lat, output int wec);
      drive(id, 1'b1, we, a, d);
      lat = 0;
      wec = 0;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (bus.ram_write_enable) wec++;
         if (m_ack[id]) begin
            lat = n;
            break;
         end
      end
      if (lat == 0) check("txn_timeout", 32'd0, 32'd1);
      drive(id, 1'b0, we, a, d);
   endtask

   logic [15:0] addr_tab [8] = '{16'h0000, 16'hFFFF, 16'h0200, 16'h0300, 16'h1234, 16'h0040, 16'h8000, 16'h7FFF};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, wec, cpu_acks;
      for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;

      // Reset held with both requesters asserting writes that double as the wrap-boundary preload.
      reset = 1'b1;
      drive(0, 1'b1, 1'b1, 16'hFFFF, 8'h11);
      drive(1, 1'b1, 1'b1, 16'h0000, 8'h22);
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_grant", 32'(bus.grant), 32'd0);
      end
      reset = 1'b0;
      step();
      check("rst_first_dsp", 32'(bus.grant), 32'd2);
      step();
      drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
      check("rst_then_cpu", 32'(bus.grant), 32'd1);
      step();
      drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
      step();

      // CPU write then read back.
      run_txn(0, 1'b1, 16'h1234, 8'hA5, lat, wec);
      check("wr_latency", 32'(lat), 32'd2);
      check("wr_we_cycles", 32'(wec), 32'd1);
      run_txn(0, 1'b0, 16'h1234, 8'h00, lat, wec);
      check("rd_latency", 32'(lat), 32'd2);
      check("rd_data", 32'(bus.cpu_rdata), 32'hA5);
      check("rd_we_cycles", 32'(wec), 32'd0);

      // Wrap boundary: the two end addresses stay distinct.
      run_txn(0, 1'b0, 16'hFFFF, 8'h00, lat, wec);
      check("wrap_ffff", 32'(bus.cpu_rdata), 32'h11);
      run_txn(1, 1'b0, 16'h0000, 8'h00, lat, wec);
      check("wrap_0000", 32'(bus.dsp_rdata), 32'h22);

      // Simultaneous reads: DSP first, CPU granted at DSP's completion edge.
      run_txn(1, 1'b1, 16'h0200, 8'h3C, lat, wec);
      run_txn(0, 1'b1, 16'h0300, 8'h7E, lat, wec);
      step();
      drive(0, 1'b1, 1'b0, 16'h0300, 8'h00);
      drive(1, 1'b1, 1'b0, 16'h0200, 8'h00);
      step();
      check("sim_dsp_first", 32'(bus.grant), 32'd2);
      step();
      check("sim_dsp_ack", 32'(bus.dsp_ack), 32'd1);
      check("sim_dsp_data", 32'(bus.dsp_rdata), 32'h3C);
      check("sim_cpu_noidle", 32'(bus.grant), 32'd1);
      drive(1, 1'b0, 1'b0, 16'h0200, 8'h00);
      step();
      check("sim_cpu_ack", 32'(bus.cpu_ack), 32'd1);
      check("sim_cpu_data", 32'(bus.cpu_rdata), 32'h7E);
      drive(0, 1'b0, 1'b0, 16'h0300, 8'h00);
      step();

      // Continuous DSP traffic with CPU held: the CPU must still be served.
      drive(0, 1'b1, 1'b0, 16'h0300, 8'h00);
      drive(1, 1'b1, 1'b0, 16'h0200, 8'h00);
      cpu_acks = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (bus.cpu_ack) cpu_acks++;
      end
      check("starve_cpu_served", 32'(cpu_acks > 0), 32'd1);
      drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
      drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
      step();
      step();

      // Reset landing on the completion edge of a CPU write.
      drive(0, 1'b1, 1'b1, 16'h0040, 8'h5A);
      step();
      check("mid_grant", 32'(bus.grant), 32'd1);
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
      step();
      check("mid_no_ack", 32'(bus.cpu_ack), 32'd0);
      check("mid_idle", 32'(bus.grant), 32'd0);
      reset = 1'b0;
      step();
      run_txn(0, 1'b0, 16'h0040, 8'h00, lat, wec);
      check("mid_committed", 32'(bus.cpu_rdata), 32'h5A);

      // Randomized traffic over a small address set, all written first so every read has a known value.
      for (int i = 0; i < 8; i++) run_txn(i % 2, 1'b1, addr_tab[i], 8'($urandom), lat, wec);
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if ($urandom_range(99) < 2) begin
            reset = 1'b1;
            drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
            drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
            step();
            reset = 1'b0;
         end else begin
            step();
         end
         for (int id = 0; id < 2; id++) begin
            logic cur;
            cur = (id == 0) ? bus.cpu_req : bus.dsp_req;
            if ((cur && m_ack[id] && $urandom_range(1) == 1) || (!cur && $urandom_range(99) < 40))
               drive(id, 1'b1, 1'($urandom), addr_tab[$urandom_range(7)], 8'($urandom));
            else if (cur && (m_ack[id] || $urandom_range(99) < 5))
               drive(id, 1'b0, 1'b0, 16'h0000, 8'h00);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
